slave_mem_responder: RTL and testbench

Responder end of the crossbar request/acknowledge protocol. It sits on a crossbar slave port and serves Master transactions against a local word-addressed register memory. Each accepted request is held for a programmable number of wait cycles, then completed with a single-cycle acknowledge. On a read, the returned data is presented with that acknowledge. It is the addressable counterpart to the initiator-side Master and is used where a port needs real storage behind it.

---
 rtl/crossbar_pkg.sv | 16 +
 rtl/slave_mem_responder.sv | 105 ++++++++++
 tb/tb_slave_mem_responder.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/crossbar_pkg.sv
// Shared crossbar definitions: command encoding, responder FSM states and bus width.
package crossbar_pkg;

  localparam int DATA_W = 32;

  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    ACK     = 2'd2,
    RELEASE = 2'd3
  } state_t;

endpackage

// File: rtl/slave_mem_responder.sv
// Crossbar slave-port responder backed by a word-addressed register memory,
// completing each request after pDelay wait cycles with a one-cycle ack.
module slave_mem_responder
  import crossbar_pkg::*;
#(
  parameter logic [31:0] pDelay = 32'd5,
  parameter int          pDepth = 16
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              slave_req,
  input  logic [DATA_W-1:0] slave_addr,
  input  logic              slave_cmd,
  input  logic [DATA_W-1:0] slave_wdata,
  output logic              slave_ack,
  output logic [DATA_W-1:0] slave_rdata,
  output logic              oBusy
);

  localparam int AW = $clog2(pDepth);

  state_t              state_reg, state_next;
  logic [31:0]         cnt_reg;
  logic [DATA_W-1:2]   addr_reg;
  logic                cmd_reg;
  logic [DATA_W-1:0]   wdata_reg;
  logic [DATA_W-1:0]   rdata_reg;
  logic [DATA_W-1:0]   mem_reg [pDepth];

  logic                commit;
  logic                in_range;
  logic [AW-1:0]       idx;

  assign idx      = addr_reg[2 +: AW];
  assign in_range = (addr_reg < (DATA_W-2)'(pDepth));

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    commit     = 1'b0;
    slave_ack  = 1'b0;
    oBusy      = 1'b1;
    case (state_reg)
      IDLE: begin
        oBusy = 1'b0;
        if (slave_req) state_next = WAIT;
      end
      WAIT: begin
        if (cnt_reg == 32'd0) begin
          state_next = ACK;
          commit     = 1'b1;
        end
      end
      ACK: begin
        slave_ack  = 1'b1;
        state_next = RELEASE;
      end
      RELEASE: begin
        // Waiting for req low guarantees a held request is served only once.
        if (!slave_req) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Request fields are captured only at acceptance; later bus changes are ignored.
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      cnt_reg   <= 32'd0;
      addr_reg  <= '0;
      cmd_reg   <= CMD_READ;
      wdata_reg <= '0;
    end else if (state_reg == IDLE && slave_req) begin
      cnt_reg   <= pDelay;
      addr_reg  <= slave_addr[DATA_W-1:2];
      cmd_reg   <= slave_cmd;
      wdata_reg <= slave_wdata;
    end else if (state_reg == WAIT && cnt_reg != 32'd0) begin
      cnt_reg <= cnt_reg - 32'd1;
    end
  end

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      for (int i = 0; i < pDepth; i++) mem_reg[i] <= '0;
    end else if (commit && cmd_reg == CMD_WRITE && in_range) begin
      mem_reg[idx] <= wdata_reg;
    end
  end

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      rdata_reg <= '0;
    end else if (commit && cmd_reg == CMD_READ) begin
      rdata_reg <= in_range ? mem_reg[idx] : '0;
    end
  end

  assign slave_rdata = rdata_reg;

endmodule

// File: tb/tb_slave_mem_responder.sv
// Scoreboard bench for slave_mem_responder: driver pushes expected responses,
// a negedge monitor checks every ack, reset outputs and busy during held requests.
module tb_slave_mem_responder;

  localparam int P_DELAY = 5;
  localparam int P_DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req = 1'b0;
  logic [31:0] addr = '0;
  logic        cmd = 1'b0;
  logic [31:0] wdata = '0;
  logic        ack;
  logic [31:0] rdata;
  logic        busy;

  slave_mem_responder #(.pDelay(32'(P_DELAY)), .pDepth(P_DEPTH)) dut (
    .iClk(clk), .iRst(rst), .slave_req(req), .slave_addr(addr), .slave_cmd(cmd),
    .slave_wdata(wdata), .slave_ack(ack), .slave_rdata(rdata), .oBusy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rd;
    logic [31:0] data;
    longint      acc;
    logic [31:0] a;
  } exp_t;

  exp_t        exq[$];
  logic [31:0] mdl [P_DEPTH];
  longint      cyc = 0;
  int          timeouts = 0;
  bit          expect_busy = 1'b0;
  bit          done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: owns all comparison counters.
  int          tests = 0;
  int          fails = 0;
  int          seen_to = 0;
  logic [31:0] last_rd = '0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      exq.delete();
      last_rd = '0;
      tests++;
      if (ack !== 1'b0 || rdata !== 32'h0 || busy !== 1'b0) begin
        fails++;
        $display("FAIL reset_out: ack=%b rdata=%h busy=%b, want 0/0/0", ack, rdata, busy);
      end
    end else if (ack) begin
      tests++;
      if (exq.size() == 0) begin
        fails++;
        $display("FAIL unexpected_ack at cycle %0d", cyc);
      end else begin
        e = exq.pop_front();
        if (cyc != e.acc + P_DELAY + 1) begin
          fails++;
          $display("FAIL ack_timing addr=%h: ack at cycle %0d, want %0d", e.a, cyc, e.acc + P_DELAY + 1);
        end else if (e.rd && rdata !== e.data) begin
          fails++;
          $display("FAIL read_data addr=%h: got %h, want %h", e.a, rdata, e.data);
        end else if (!e.rd && rdata !== last_rd) begin
          fails++;
          $display("FAIL rdata_hold_on_write addr=%h: got %h, want %h", e.a, rdata, last_rd);
        end else begin
          $display("[TB] %s addr=%h data=%h ack@%0d ok", e.rd ? "RD" : "WR", e.a, e.rd ? rdata : e.data, cyc);
        end
        if (e.rd) last_rd = e.data;
      end
    end
    if (rst && expect_busy) begin
      tests++;
      if (busy !== 1'b1) begin
        fails++;
        $display("FAIL busy_held: busy=%b, want 1", busy);
      end
    end
    if (timeouts != seen_to) begin
      tests++;
      fails++;
      $display("FAIL handshake_timeout: %0d timeouts, want 0", timeouts);
      seen_to = timeouts;
    end
    if (done) begin
      tests++;
      if (exq.size() != 0) begin
        fails++;
        $display("FAIL missing_ack: %0d outstanding, want 0", exq.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
    end
  end

  task automatic txn(input logic c, input logic [31:0] a, input logic [31:0] d,
                     input int hold, input bit early, input int abort);
    exp_t e;
    int   n;
    bit   inr;
    int   idx;
    @(negedge clk);
    n = 0;
    while (busy && n < 64) begin @(negedge clk); n++; end
    if (busy) timeouts++;
    req = 1'b1; cmd = c; addr = a; wdata = d;
    inr   = (a[31:2] < 30'(P_DEPTH));
    idx   = int'(a[5:2]);
    e.rd  = (c == 1'b0);
    e.data = c ? d : (inr ? mdl[idx] : 32'h0);
    e.acc = cyc + 1;
    e.a   = a;
    if (c && inr) mdl[idx] = d;
    if (abort == 0) exq.push_back(e);
    @(negedge clk);
    addr = $urandom; wdata = $urandom; cmd = 1'($urandom);
    if (early) req = 1'b0;
    if (abort > 0) begin
      repeat (abort - 1) @(negedge clk);
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk); @(negedge clk);
      req = 1'b0;
      for (int i = 0; i < P_DEPTH; i++) mdl[i] = '0;
      rst = 1'b1;
      $display("[TB] WR addr=%h interrupted by reset", a);
      return;
    end
    n = 0;
    while (!ack && n < P_DELAY + 10) begin @(negedge clk); n++; end
    if (!ack) timeouts++;
    if (!early) begin
      expect_busy = 1'b1;
      repeat (hold) @(negedge clk);
      expect_busy = 1'b0;
    end
    req = 1'b0;
    addr = $urandom; wdata = $urandom;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < P_DEPTH; i++) mdl[i] = '0;
    repeat (5) begin
      @(negedge clk);
      req = 1'($urandom); cmd = 1'($urandom); addr = $urandom; wdata = $urandom;
    end
    @(negedge clk);
    req = 1'b0;
    rst = 1'b1;

    txn(1'b0, 32'h0, 32'h0, 0, 1'b0, 0);
    txn(1'b1, 32'h8, 32'hA5A5_0001, 0, 1'b0, 0);
    txn(1'b0, 32'h8, 32'h0, 0, 1'b0, 0);
    txn(1'b1, 32'hC, 32'h1234_5678, 0, 1'b0, 0);
    txn(1'b0, 32'hF, 32'h0, 0, 1'b0, 0);
    txn(1'b1, 32'h40, 32'hDEAD_BEEF, 0, 1'b0, 0);
    txn(1'b0, 32'h40, 32'h0, 0, 1'b0, 0);
    for (int w = 0; w < P_DEPTH; w++) txn(1'b0, 32'(w * 4), 32'h0, 0, 1'b0, 0);
    txn(1'b1, 32'h10, 32'hC0DE_0010, 20, 1'b0, 0);
    txn(1'b0, 32'h10, 32'h0, 0, 1'b0, 0);
    txn(1'b1, 32'h4, 32'hFFFF_FFFF, 0, 1'b0, 3);
    txn(1'b0, 32'h4, 32'h0, 0, 1'b0, 0);

    for (int k = 0; k < 40; k++) begin
      logic [31:0] ra;
      ra = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 127));
      txn(1'($urandom), ra, $urandom, $urandom_range(0, 3), $urandom_range(0, 7) == 0, 0);
    end

    repeat (P_DELAY + 6) @(negedge clk);
    done = 1'b1;
  end

endmodule
